hazard_stall_unit: RTL

Stall-side companion to the ID-stage operand forwarding logic of the 5-stage MIPS pipeline. Where forwarding can satisfy a dependency, the pipeline keeps running. Where it cannot, this block freezes PC and IF/ID and injects a bubble into ID/EX:
- load-use;
- branch or `jr` operand not yet available at MEM/WB.

A small FSM sequences multi-cycle stalls, and an optional counter reports the total number of stall cycles to the debug unit.

---
 rtl/hazard_stall_unit.sv | 89 ++++++++
 1 files changed

// File: rtl/hazard_stall_unit.sv
// Stall/bubble generator for the ID stage of the 5-stage MIPS pipeline.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_COUNTER_EN.
module hazard_stall_unit #(
    parameter int NB_REG_ADDR = 5,
    parameter int NB_CNT      = 32
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_valid,
    input  logic [NB_REG_ADDR-1:0] i_rs,
    input  logic [NB_REG_ADDR-1:0] i_rt,
    input  logic                   i_uses_rt,
    input  logic                   i_branch,
    input  logic                   i_jump_rs,
    input  logic                   i_jinst,
    input  logic [NB_REG_ADDR-1:0] i_rd_ex,
    input  logic                   i_we_ex,
    input  logic                   i_memread_ex,
    input  logic [NB_REG_ADDR-1:0] i_rd_mem,
    input  logic                   i_we_mem,
    input  logic                   i_memread_mem,
    output logic                   o_stall_pc,
    output logic                   o_stall_ifid,
    output logic                   o_bubble_idex,
    output logic [NB_CNT-1:0]      o_stall_count
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t r_state;

    logic w_ma_ex, w_mb_ex, w_ma_mem, w_mb_mem;
    logic w_dep_ex, w_dep_mem, w_ctrl;
    logic w_need1, w_need2, w_stall;

    // jr/jalr only read rs, so the rt comparison is suppressed for them.
    assign w_ma_ex  = (i_rs == i_rd_ex)  && (i_rd_ex  != '0) && !i_jinst;
    assign w_mb_ex  = (i_rt == i_rd_ex)  && (i_rd_ex  != '0) && i_uses_rt && !i_jump_rs && !i_jinst;
    assign w_ma_mem = (i_rs == i_rd_mem) && (i_rd_mem != '0) && !i_jinst;
    assign w_mb_mem = (i_rt == i_rd_mem) && (i_rd_mem != '0) && i_uses_rt && !i_jump_rs && !i_jinst;

    assign w_dep_ex  = (w_ma_ex  || w_mb_ex)  && i_we_ex;
    assign w_dep_mem = (w_ma_mem || w_mb_mem) && i_we_mem;
    assign w_ctrl    = i_branch || i_jump_rs;

    assign w_need2 = w_ctrl && w_dep_ex && i_memread_ex;
    assign w_need1 = (w_dep_ex && i_memread_ex)
                  || (w_ctrl && w_dep_ex)
                  || (w_ctrl && w_dep_mem && i_memread_mem);

    assign w_stall = i_reset && ((r_state == ST_HOLD) || w_need1 || w_need2);

    assign o_stall_pc    = w_stall;
    assign o_stall_ifid  = w_stall;
    assign o_bubble_idex = w_stall;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_RUN;
        end else if (i_valid) begin
            case (r_state)
                ST_RUN:  r_state <= w_need2 ? ST_HOLD : ST_RUN;
                ST_HOLD: r_state <= ST_RUN;
                default: r_state <= ST_RUN;
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNTER_EN
    logic [NB_CNT-1:0] r_stall_count;

    // Saturating: the debug unit prefers a pinned maximum over a wrap.
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            r_stall_count <= '0;
        end else if (i_valid && w_stall && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + NB_CNT'(1);
        end
    end

    assign o_stall_count = r_stall_count;
`else
    assign o_stall_count = '0;
`endif

endmodule
